// File: rtl/vreg_pkg.sv
// Shared definitions for the vector register file write and read paths.
// Ports: none (package). Provides the register file geometry, vlmul encodings,
// the write-state enum and the group alignment / beat-count helpers.
package vreg_pkg;

  localparam int NUM_REGS = 32;
  localparam int REG_W    = 32;
  localparam int GROUP_W  = 256;
  localparam int SEL_W    = 5;
  localparam int VLMUL_W  = 3;
  localparam int BEAT_W   = 3;

  // Group size encodings (registers per group).
  localparam logic [VLMUL_W-1:0] LMUL_1 = 3'b000;
  localparam logic [VLMUL_W-1:0] LMUL_2 = 3'b001;
  localparam logic [VLMUL_W-1:0] LMUL_4 = 3'b010;
  localparam logic [VLMUL_W-1:0] LMUL_8 = 3'b011;

  typedef enum logic {
    WR_IDLE  = 1'b0,
    WR_WRITE = 1'b1
  } wr_state_e;

  // A group is legal when vlmul is a defined encoding and the base register
  // index is a multiple of the group size. Shared with the read selector.
  function automatic logic group_aligned(input logic [SEL_W-1:0]   sel,
                                         input logic [VLMUL_W-1:0] vlmul);
    logic ok;
    ok = 1'b0;
    case (vlmul)
      LMUL_1:  ok = 1'b1;
      LMUL_2:  ok = (sel[0]   == 1'b0);
      LMUL_4:  ok = (sel[1:0] == 2'b00);
      LMUL_8:  ok = (sel[2:0] == 3'b000);
      default: ok = 1'b0;
    endcase
    return ok;
  endfunction

  // Index of the final beat of a group (n-1). Illegal encodings map to 0;
  // they never reach the write path.
  function automatic logic [BEAT_W-1:0] group_last_beat(input logic [VLMUL_W-1:0] vlmul);
    logic [BEAT_W-1:0] last;
    last = '0;
    case (vlmul)
      LMUL_1:  last = 3'd0;
      LMUL_2:  last = 3'd1;
      LMUL_4:  last = 3'd3;
      LMUL_8:  last = 3'd7;
      default: last = 3'd0;
    endcase
    return last;
  endfunction

endpackage

// File: rtl/register_in_write.sv
// Vector register file (32 x 32b) with a grouped write port; commits 1/2/4/8 registers, one per cycle.
// Latency: accept at E0, beat k visible after E(k+1), wr_done the cycle after the last beat.
// Backpressure: wr_ready low while a group is being written and while rst_n is low.
// Ports: clk, rst_n (sync, active-low), wr_valid/wr_ready handshake, wr_sel/wr_vlmul/wr_data
// request fields, registers (flat 1024b file, r_i at [32i+31:32i]), wr_done/wr_err pulses.
module register_in_write
  import vreg_pkg::*;
(
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      wr_valid,
  output logic                      wr_ready,
  input  logic [SEL_W-1:0]          wr_sel,
  input  logic [VLMUL_W-1:0]        wr_vlmul,
  input  logic [GROUP_W-1:0]        wr_data,
  output logic [NUM_REGS*REG_W-1:0] registers,
  output logic                      wr_done,
  output logic                      wr_err
);

  wr_state_e state;
  wr_state_e state_nxt;

  logic                 accept;
  logic                 legal;
  logic                 beat_en;
  logic                 last_beat;

  logic [SEL_W-1:0]     cap_sel;
  logic [BEAT_W-1:0]    cap_last;
  logic [GROUP_W-1:0]   cap_data;
  logic [BEAT_W-1:0]    beat;

  logic [SEL_W-1:0]     wr_idx;
  logic [REG_W-1:0]     beat_dat;

  logic [REG_W-1:0]     rf [NUM_REGS];

  assign accept = wr_valid && wr_ready;
  assign legal  = group_aligned(wr_sel, wr_vlmul);

  // Alignment guarantees base+beat stays within 0..31, so a 5-bit add suffices.
  assign wr_idx   = cap_sel + {{(SEL_W-BEAT_W){1'b0}}, beat};
  assign beat_dat = cap_data[beat*REG_W +: REG_W];

  // ---------------------------------------------------------------------------
  // FSM: state register
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= WR_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // ---------------------------------------------------------------------------
  // FSM: next state
  // ---------------------------------------------------------------------------
  always_comb begin
    state_nxt = state;
    case (state)
      WR_IDLE: begin
        // Rejected requests leave the FSM in IDLE so the next cycle can accept.
        if (accept && legal) begin
          state_nxt = WR_WRITE;
        end
      end
      WR_WRITE: begin
        if (beat == cap_last) begin
          state_nxt = WR_IDLE;
        end
      end
      default: state_nxt = WR_IDLE;
    endcase
  end

  // ---------------------------------------------------------------------------
  // FSM: outputs
  // ---------------------------------------------------------------------------
  always_comb begin
    wr_ready  = rst_n && (state == WR_IDLE);
    beat_en   = (state == WR_WRITE);
    last_beat = (state == WR_WRITE) && (beat == cap_last);
  end

  // ---------------------------------------------------------------------------
  // Request capture, beat counter and status pulses
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cap_sel  <= '0;
      cap_last <= '0;
      cap_data <= '0;
      beat     <= '0;
      wr_done  <= 1'b0;
      wr_err   <= 1'b0;
    end else begin
      // Done comes only from WRITE and err only from an IDLE accept, so the
      // two pulses are mutually exclusive by construction.
      wr_done <= last_beat;
      wr_err  <= accept && !legal;

      if (accept && legal) begin
        cap_sel  <= wr_sel;
        cap_last <= group_last_beat(wr_vlmul);
        cap_data <= wr_data;
        beat     <= '0;
      end else if (beat_en) begin
        beat <= last_beat ? '0 : beat + 3'd1;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Register file: one register committed per WRITE cycle
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      // A group interrupted by reset is discarded along with the whole file.
      for (int i = 0; i < NUM_REGS; i++) begin
        rf[i] <= '0;
      end
    end else if (beat_en) begin
      rf[wr_idx] <= beat_dat;
    end
  end

  for (genvar g = 0; g < NUM_REGS; g++) begin : g_flat
    assign registers[g*REG_W +: REG_W] = rf[g];
  end

endmodule
